// File: rtl/uart_tx_arb.sv
// Message-granular round-robin arbiter that lets NUM_REQ byte sources share
// one UART transmitter, launching one byte per utx_en pulse.
module uart_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   s_valid,
    input  logic [8*NUM_REQ-1:0] s_data,
    input  logic [NUM_REQ-1:0]   s_last,
    output logic [NUM_REQ-1:0]   s_ready,
    output logic                 utx_en,
    output logic [7:0]           utx_data,
    input  logic                 utx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_W-1:0]     grant_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t           state;
    logic             done;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic [7:0]       s_bytes [NUM_REQ];
    logic             in_send;
    logic             xfer;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            s_bytes[i] = s_data[8*i +: 8];
        end
    end

    // Scan from the farthest candidate back to the nearest one after
    // last_owner; the final hit is the round-robin winner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (s_valid[cand]) begin
                winner = cand;
            end
        end
    end

    assign in_send  = (state == SEND);
    assign xfer     = in_send && s_valid[grant_idx] && !utx_busy;
    assign utx_en   = xfer;
    assign utx_data = in_send ? s_bytes[grant_idx] : 8'h00;
    // grant is one-hot while sending, so it doubles as the ready mask.
    assign s_ready  = (in_send && !utx_busy) ? grant : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            grant_idx  <= '0;
            done       <= 1'b0;
            last_owner <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|s_valid) begin
                        grant     <= NUM_REQ'(1) << winner;
                        grant_idx <= winner;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        done  <= s_last[grant_idx];
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // One idle cycle lets the transmitter raise utx_busy.
                    if (done) begin
                        state      <= IDLE;
                        last_owner <= grant_idx;
                        grant      <= '0;
                        grant_idx  <= '0;
                        done       <= 1'b0;
                    end else begin
                        state <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
